// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding an 8-N-1 serialiser.
// Define UART_TX_PARITY_EN for 8-E-1 frames (even parity bit between data and stop).
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk_100mhz,
   input  logic                          rst_n,
   input  logic [7:0]                    data_in,
   input  logic                          valid_in,
   output logic                          ready_out,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   state_t        r_state;
   logic [CW-1:0] r_baud;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_tx;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_bit_end;

   always_comb begin
      w_empty   = (r_wr_ptr == r_rd_ptr);
      w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      w_push    = valid_in && !w_full;
      w_bit_end = (r_baud == BAUD_LAST);
      // Pop when leaving IDLE or on the last stop cycle, so frames chain with no gap
      w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
   end

   always_ff @(posedge clk_100mhz) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_in;
   end

   // tx is registered from the current state, so the line lags the state by one cycle
   always_ff @(posedge clk_100mhz) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         if ((r_state == S_IDLE) || w_bit_end) r_baud <= '0;
         else                                   r_baud <= r_baud + CW'(1);

         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (!w_empty) begin
                  r_shift <= r_mem[r_rd_ptr[AW-1:0]];
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_tx <= 1'b0;
               if (w_bit_end) begin
                  r_bit_idx <= '0;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               r_tx <= r_shift[r_bit_idx];
               if (w_bit_end) begin
                  r_bit_idx <= r_bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                  if (r_bit_idx == 3'd7) r_state <= S_PARITY;
`else
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
`endif
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               r_tx <= ^r_shift;
               if (w_bit_end) r_state <= S_STOP;
            end
`endif
            S_STOP: begin
               r_tx <= 1'b1;
               if (w_bit_end) begin
                  if (!w_empty) begin
                     r_shift <= r_mem[r_rd_ptr[AW-1:0]];
                     r_state <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx         = r_tx;
   assign ready_out  = !w_full;
   assign busy       = (r_state != S_IDLE) || !w_empty;
   assign fifo_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a line monitor.
// Build with UART_TX_PARITY_EN defined for the 8-E-1 variant.
module tb_uart_tx_buffered;

   localparam int CPB = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = CPB * NBITS;

   logic       clk_100mhz;
   logic       rst_n;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int mon_err = 0;
   logic [7:0] mon_q[$];
   logic       mon_par[$];
   int         mon_start[$];

   uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_100mhz (clk_100mhz),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial begin
      clk_100mhz = 1'b0;
      forever #5 clk_100mhz = ~clk_100mhz;
   end

   always @(posedge clk_100mhz) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task tick;
      @(posedge clk_100mhz);
      #1;
   endtask

   // Expected line level for every bit slot of one frame, start bit at index 0
   function automatic logic [10:0] frame_model(input logic [7:0] b);
      logic [10:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = b;
`ifdef UART_TX_PARITY_EN
      f[9] = ^b;
`endif
      return f;
   endfunction

   // Called at the cycle the start bit appears; leaves the bench one frame later
   task automatic check_frame(input string tag, input logic [7:0] b);
      logic [10:0] f;
      f = frame_model(b);
      for (int c = 0; c < FRAME; c++) begin
         if ((c % CPB == 0) || (c % CPB == CPB - 1)) chk(tag, tx, f[c / CPB]);
         tick();
      end
   endtask

   task automatic mon_expect(input string tag, input logic [7:0] b);
      chk({tag, "_present"}, mon_q.size() > 0, 1);
      if (mon_q.size() > 0) chk(tag, mon_q.pop_front(), b);
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while (busy && n < lim) begin
         tick();
         n++;
      end
      chk("drain_busy", busy, 0);
   endtask

   // Independent receiver: samples each bit at its middle
   initial begin
      logic prev;
      logic [7:0] b;
      int st;
      prev = 1'b1;
      forever begin
         @(posedge clk_100mhz);
         #1;
         if (prev && !tx) begin
            st = cyc;
            repeat (CPB / 2) @(posedge clk_100mhz);
            #1;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(posedge clk_100mhz);
               #1;
               b[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(posedge clk_100mhz);
            #1;
            mon_par.push_back(tx);
`endif
            repeat (CPB) @(posedge clk_100mhz);
            #1;
            if (tx !== 1'b1) mon_err++;
            mon_q.push_back(b);
            mon_start.push_back(st);
         end
         prev = tx;
      end
   end

   initial begin
      int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};
      logic exp_rdy[6] = '{1, 1, 1, 1, 0, 0};
      int lows;
      int s0;

      rst_n = 1'b0;
      valid_in = 1'b0;
      data_in = 8'h00;
      repeat (3) tick();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ready", ready_out, 1);
      rst_n = 1'b1;
      tick();

      // single byte
      data_in = 8'hA5;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      data_in = 8'h00;
      chk("single_cnt_n", fifo_count, 1);
      chk("single_busy_n", busy, 1);
      tick();
      chk("single_cnt_n1", fifo_count, 0);
      chk("single_tx_n1", tx, 1);
      tick();
      chk("single_fall_n2", tx, 0);
      check_frame("single_frame", 8'hA5);
      chk("single_busy_end", busy, 0);
      chk("single_tx_end", tx, 1);
      mon_expect("single_mon", 8'hA5);
`ifdef UART_TX_PARITY_EN
      chk("par_a5", mon_par.pop_front(), 0);
`endif

      // back-to-back
      repeat (3) tick();
      mon_q.delete();
      mon_start.delete();
      mon_par.delete();
      data_in = 8'hA5;
      valid_in = 1'b1;
      tick();
      data_in = 8'h3C;
      tick();
      valid_in = 1'b0;
      data_in = 8'hEE;
      chk("b2b_cnt", fifo_count, 1);
      tick();
      chk("b2b_fall1", tx, 0);
      check_frame("b2b_frame1", 8'hA5);
      chk("b2b_fall2", tx, 0);
      check_frame("b2b_frame2", 8'h3C);
      chk("b2b_busy_end", busy, 0);
      mon_expect("b2b_mon1", 8'hA5);
      mon_expect("b2b_mon2", 8'h3C);
      chk("b2b_gap", (mon_start.size() == 2) ? mon_start[1] - mon_start[0] : -1, FRAME);

      // FIFO full, dropped push, simultaneous push/pop at count 3
      repeat (3) tick();
      mon_q.delete();
      mon_par.delete();
      for (int i = 0; i < 6; i++) begin
         data_in = 8'(i + 1);
         valid_in = 1'b1;
         tick();
         chk($sformatf("full_cnt%0d", i), fifo_count, exp_cnt[i]);
         chk($sformatf("full_rdy%0d", i), ready_out, exp_rdy[i]);
      end
      valid_in = 1'b0;
      data_in = 8'hEE;
      repeat (FRAME - 5) tick();
      chk("full_rdy_prepop", ready_out, 0);
      chk("full_cnt_prepop", fifo_count, 4);
      tick();
      chk("full_rdy_pop", ready_out, 1);
      chk("full_cnt_pop", fifo_count, 3);
      repeat (FRAME - 1) tick();
      chk("pp_cnt_before", fifo_count, 3);
      data_in = 8'h07;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      data_in = 8'hEE;
      chk("pp_cnt_after", fifo_count, 3);
      wait_idle(2000);
      repeat (4) tick();
      chk("full_nframes", mon_q.size(), 6);
      mon_expect("full_b1", 8'h01);
      mon_expect("full_b2", 8'h02);
      mon_expect("full_b3", 8'h03);
      mon_expect("full_b4", 8'h04);
      mon_expect("full_b5", 8'h05);
      mon_expect("full_b7", 8'h07);

      // reset mid-frame
      repeat (3) tick();
      valid_in = 1'b1;
      data_in = 8'hFF;
      tick();
      data_in = 8'h11;
      tick();
      data_in = 8'h22;
      tick();
      valid_in = 1'b0;
      chk("mrst_cnt_q", fifo_count, 2);
      repeat (17) tick();
      chk("mrst_bit3", tx, 1);
      rst_n = 1'b0;
      tick();
      chk("mrst_tx", tx, 1);
      chk("mrst_cnt", fifo_count, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ready", ready_out, 1);
      rst_n = 1'b1;
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (tx !== 1'b1) lows++;
      end
      chk("mrst_quiet", lows, 0);
      chk("mrst_cnt_end", fifo_count, 0);

`ifdef UART_TX_PARITY_EN
      mon_q.delete();
      mon_par.delete();
      data_in = 8'h07;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      chk("par07_fall", tx, 0);
      check_frame("par07_frame", 8'h07);
      chk("par07_busy_end", busy, 0);
      mon_expect("par07_mon", 8'h07);
      chk("par07_bit", (mon_par.size() > 0) ? mon_par.pop_front() : 1'bx, 1);
      s0 = 44;
      chk("par_frame_len", FRAME, s0);
`endif

      chk("mon_stop_err", mon_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that serialises bytes from the solver datapath onto the board `tx` line at 8-N-1 (8-E-1 optional), 9600 baud from the 100 MHz clock. It is the transmit-side counterpart of the existing UART receive path in `top_level`. It accepts bytes through a valid/ready handshake into an internal FIFO, so the solver can dump a result row without waiting on the line. Frames go out back-to-back while the FIFO holds data.

## Interface
Parameters:
- `CLKS_PER_BIT`, 10417, clock cycles per bit period; must be ≥ 2.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 2.

Ports:
- `clk_100mhz`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `data_in`  in  8  byte to transmit.
- `valid_in`  in  1  `data_in` is valid this cycle.
- `ready_out`  out  1  FIFO can accept a byte; high when FIFO is not full.
- `tx`  out  1  serial line; registered; idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: a byte is accepted on a rising edge where `valid_in && ready_out`. A push while full is ignored, and no byte is lost from the FIFO.
- FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE, or STOP → START when the FIFO is non-empty.
  - IDLE: `tx`=1. When the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each held for `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On its last cycle, pop the next byte if the FIFO is non-empty and go straight to START, with no idle gap. Otherwise go to IDLE.
- The baud counter runs 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary. Its width is $clog2(`CLKS_PER_BIT`).
- FIFO: circular buffer with read/write pointers of log2(`FIFO_DEPTH`)+1 bits; pointers wrap modulo 2·depth.
  - full = MSBs differ and the rest are equal.
  - empty = pointers equal.
  - Push and pop in the same cycle are both honoured, and `fifo_count` is unchanged.
  - Push into an empty FIFO while in IDLE: the byte is visible for pop on the next cycle; no bypass path.
- `busy` = (state ≠ IDLE) || !empty.
- `data_in` is sampled only at the accept edge; later changes have no effect.

## Timing
- Reset values (on `rst_n`=0 at a rising edge):
  - `tx`=1, `busy`=0, `fifo_count`=0, `ready_out`=1.
  - State IDLE, both pointers 0, baud counter 0, bit index 0.
- Reset mid-frame aborts the frame: `tx` is high from the next edge and all FIFO contents are discarded.
- Latency: a byte accepted at edge N into an empty, idle block is popped at edge N+1. `tx` falls at edge N+2.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
  - Consecutive frames start exactly 10·`CLKS_PER_BIT` (or 11·`CLKS_PER_BIT`) cycles apart.
- `ready_out` deasserts on the edge at which `fifo_count` reaches `FIFO_DEPTH`. It reasserts on the edge following a pop.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Frames are 11 bits (8-E-1).
- Undefined: no PARITY state; 8-N-1, 10-bit frames. No parity logic is synthesised.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 unless stated.
- Reset: hold `rst_n`=0 for 3 cycles → `tx`=1, `busy`=0, `fifo_count`=0, `ready_out`=1.
- Single byte: push 0xA5 at edge N → `tx` falls at N+2. Line then carries 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles wide, then `busy`=0.
- Back-to-back: push 0xA5 and 0x3C on consecutive cycles → the second start bit begins exactly 40 cycles after the first. There is no idle cycle between the frames, and the decoded bytes are 0xA5 then 0x3C.
- FIFO full: push 6 bytes 0x01..0x06 on consecutive cycles, holding `valid_in` high.
  - `ready_out` drops after 0x05: four bytes in the FIFO after 0x01 was popped.
  - 0x06 is dropped.
  - The line carries 0x01..0x05 in order.
  - A simultaneous push/pop while at count 3 leaves count at 3.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0xFF with two bytes queued → `tx`=1 on the next edge, `fifo_count`=0. No further frames follow after release.
- Parity build (`UART_TX_PARITY_EN`):
  - 0xA5 → parity bit 0, frame 44 cycles.
  - 0x07 → parity bit 1.
